imem_fetch_queue: RTL and testbench
===================================

IMEM_FETCH_QUEUE -- requirements
Module: imem_fetch_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, instruction queue entries (power of two, 2..8); RESET_PC, 32'h0, first fetch byte address.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 mem_req  out  1  registered fetch request to instruction memory.
REQ-005 mem_addr  out  6  word address, equal to fetch_pc[7:2].
REQ-006 mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
REQ-007 mem_rdata  in  32  instruction word returned by memory.
REQ-008 instr  out  32  head-of-queue instruction, feeding the datapath instr input.
REQ-009 instr_pc  out  32  byte address of instr.
REQ-010 instr_valid  out  1  queue not empty.
REQ-011 instr_ready  in  1  consumer accepts head when high with instr_valid high (pop).
REQ-012 redirect  in  1  one-cycle flush request for branch or jump.
REQ-013 redirect_pc  in  32  new fetch byte address; bits [1:0] are ignored and treated as 0.

Function
REQ-014 Internal state SHALL be: fetch_pc (32b), queue of DEPTH {instr, pc} entries, count (0..DEPTH), and FSM state in {FETCH, WAIT, DISCARD}.
REQ-015 FETCH: if count_next < DEPTH, assert mem_req next cycle with mem_addr=fetch_pc[7:2] and go to WAIT; otherwise hold in FETCH with mem_req=0.
REQ-016 WAIT: mem_req and mem_addr SHALL stay stable until mem_ack=1.
REQ-017 WAIT with mem_ack=1: push {mem_rdata, fetch_pc} and set fetch_pc+=4 (32-bit wrap).
REQ-018 In the same WAIT ack cycle, if count_next < DEPTH, stay in WAIT and request fetch_pc+4 back-to-back; otherwise go to FETCH with mem_req=0.
REQ-019 count_next SHALL be count + push - pop; a simultaneous push and pop leaves count unchanged.
REQ-020 Memory SHALL have at most one outstanding request; mem_ack outside WAIT/DISCARD is ignored.
REQ-021 Pop SHALL occur only when instr_valid && instr_ready; the head advances next cycle.
REQ-022 instr and instr_pc SHALL come directly from the head entry; with count=0 they are don't-care.
REQ-023 Pushed data SHALL be visible on instr one cycle after the ack edge, with no bypass.
REQ-024 redirect=1 SHALL take priority over push, pop, and request issue in the same cycle.
REQ-025 On redirect: count=0, head/tail pointers=0, fetch_pc={redirect_pc[31:2],2'b00}, and instr_valid=0 next cycle.
REQ-026 On redirect in WAIT without mem_ack: go to DISCARD and drop mem_req next cycle.
REQ-027 On redirect in WAIT with mem_ack, or in FETCH: go to FETCH; that ack's data is dropped.
REQ-028 DISCARD: the first mem_ack's data is dropped, with no push and no fetch_pc change; then go to FETCH.
REQ-029 A redirect while in DISCARD SHALL update fetch_pc and keep the state in DISCARD.
REQ-030 Queue full (count=DEPTH): no request issued; resume per REQ-015 after a pop.

Reset
REQ-031 While reset=1: mem_req=0, instr_valid=0, count=0, pointers=0, fetch_pc=RESET_PC, state=FETCH.
REQ-032 Reset during WAIT or DISCARD SHALL abandon the outstanding request; a later stale mem_ack is ignored.
REQ-033 First mem_req SHALL rise on the first posedge clk after reset deasserts, with mem_addr=RESET_PC[7:2].

Verification
REQ-034 Zero-wait memory (ack in the same cycle as mem_req), instr_ready=1 -> instr_pc sequence 0,4,8,12 on consecutive cycles; instr_valid continuous from cycle 2.
REQ-035 instr_ready=0, immediate ack -> exactly 4 pushes, count=4; mem_req low while full; one pop -> one new request at addr 4.
REQ-036 Ack delayed 3 cycles -> mem_req/mem_addr stable for 3 cycles; instr_valid rises exactly 1 cycle after ack.
REQ-037 redirect_pc=32'h23 during WAIT with ack 2 cycles later -> returned data dropped, queue empty; next request mem_addr=8, instr_pc=32'h20.
REQ-038 redirect, pop and ack in the same cycle -> count=0 next cycle; no entry from that ack appears.
REQ-039 Reset asserted mid-WAIT, then ack pulse after release -> that ack is ignored; first request at RESET_PC, instr_valid=0 until its own ack.

Source files
------------

// File: rtl/imem_fetch_queue.sv
// imem_fetch_queue: instruction fetch engine with a DEPTH-entry {instr, pc} queue and branch redirect flush
module imem_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [5:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [1:0] FETCH = 2'd0, WAIT = 2'd1, DISCARD = 2'd2;
    logic [1:0]    state, state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count, count_next;
    logic          push, pop, room;
    assign push        = state == WAIT && mem_ack && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;
    assign count_next  = count + (AW + 1)'(push) - (AW + 1)'(pop);
    assign room        = count_next < FULL;
    assign instr_valid = count != '0;
    assign instr       = q_instr[head];
    assign instr_pc    = q_pc[head];
    assign mem_addr    = fetch_pc[7:2];
    // Next state: a redirect never issues a request; an ack caught in DISCARD always returns to FETCH
    always_comb begin
        state_next = state == FETCH ? ((!redirect && room) ? WAIT : FETCH) :
                     state == WAIT  ? (redirect ? (mem_ack ? FETCH : DISCARD) :
                                       (!mem_ack || room) ? WAIT : FETCH) :
                     state == DISCARD ? (mem_ack ? FETCH : DISCARD) : FETCH;
    end
    // Control state, pointers and fetch address; redirect flushes the queue and reloads fetch_pc
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            mem_req  <= 1'b0;
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state    <= state_next;
            mem_req  <= state_next == WAIT;
            count    <= redirect ? '0 : count_next;
            head     <= redirect ? '0 : head + AW'(pop);
            tail     <= redirect ? '0 : tail + AW'(push);
            fetch_pc <= redirect ? (redirect_pc & ~32'h3) : push ? fetch_pc + 32'd4 : fetch_pc;
        end
    end
    // Queue storage: the returned word is tagged with the address it was fetched from
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= mem_rdata;
            q_pc[tail]    <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_imem_fetch_queue.sv
// tb_imem_fetch_queue: directed self-checking bench for imem_fetch_queue
module tb_imem_fetch_queue;
    logic        clk, reset, mem_req, mem_ack, instr_valid, instr_ready, redirect;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rdata, instr, instr_pc, redirect_pc, man_rdata;
    logic        auto_ack, man_ack;
    int checks = 0;
    int failures = 0;

    imem_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // Memory model: zero-wait auto mode returns 0xD0000000|word_addr, otherwise manual pulses
    assign mem_ack   = auto_ack ? mem_req : man_ack;
    assign mem_rdata = auto_ack ? (32'hD000_0000 | {26'd0, mem_addr}) : man_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; man_ack = 1'b0; man_rdata = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset;
        auto_ack = 1'b0; man_ack = 1'b1; man_rdata = 32'hBAD0_0000; instr_ready = 1'b1;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
        man_ack = 1'b0;
    endtask

    task automatic test_zero_wait;
        auto_ack = 1'b1; instr_ready = 1'b1;
        apply_reset();
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd0) begin failures++; $display("FAIL zw_first_req got=%0h/%0h exp=1/0", mem_req, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL zw_valid_c1 got=%0h exp=0", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== (32'hD000_0000 | 32'(i))) begin
                failures++;
                $display("FAIL zw_seq%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, instr_valid, instr_pc, instr, 4 * i, 32'hD000_0000 | 32'(i));
            end
        end
    endtask

    task automatic test_full;
        auto_ack = 1'b1; instr_ready = 1'b0;
        apply_reset();
        repeat (5) step();
        checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL full_stop got=%0h/%0h/%0h exp=0/1/0", mem_req, instr_valid, instr_pc); end
        repeat (2) step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_hold got=%0h exp=0", mem_req); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd4 || instr_pc !== 32'h4) begin failures++; $display("FAIL full_resume got=%0h/%0h/%0h exp=1/4/4", mem_req, mem_addr, instr_pc); end
        step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_refill got=%0h exp=0", mem_req); end
        auto_ack = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(8 + 4 * i)) begin failures++; $display("FAIL full_drain%0d got=%0h/%0h exp=1/%0h", i, instr_valid, instr_pc, 8 + 4 * i); end
        end
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%0h exp=0", instr_valid); end
    endtask

    task automatic test_delayed_ack;
        auto_ack = 1'b0; instr_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL dly_stable%0d got=%0h/%0h/%0h exp=1/0/0", i, mem_req, mem_addr, instr_valid); end
        end
        man_ack = 1'b1; man_rdata = 32'h1234_5678;
        step();
        man_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || instr_pc !== 32'h0) begin failures++; $display("FAIL dly_data got=%0h/%0h/%0h exp=1/12345678/0", instr_valid, instr, instr_pc); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd1) begin failures++; $display("FAIL dly_next_req got=%0h/%0h exp=1/1", mem_req, mem_addr); end
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL dly_popped got=%0h exp=0", instr_valid); end
    endtask

    task automatic test_redirect_wait;
        auto_ack = 1'b0; instr_ready = 1'b1;
        apply_reset();
        step();
        redirect = 1'b1; redirect_pc = 32'h23;
        step();
        redirect = 1'b0;
        checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rw_drop_req got=%0h/%0h exp=0/0", mem_req, instr_valid); end
        step();
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        step();
        man_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rw_discard got=%0h/%0h exp=0/0", instr_valid, mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd8) begin failures++; $display("FAIL rw_new_req got=%0h/%0h exp=1/8", mem_req, mem_addr); end
        man_ack = 1'b1; man_rdata = 32'h0000_600D;
        step();
        man_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== 32'h0000_600D) begin failures++; $display("FAIL rw_new_data got=%0h/%0h/%0h exp=1/20/600d", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_redirect_pop_ack;
        auto_ack = 1'b0; instr_ready = 1'b0;
        apply_reset();
        step();
        man_ack = 1'b1; man_rdata = 32'hA1;
        step();
        man_rdata = 32'hA2;
        step();
        man_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hA1) begin failures++; $display("FAIL rpa_fill got=%0h/%0h/%0h exp=1/0/a1", instr_valid, instr_pc, instr); end
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; man_ack = 1'b1; man_rdata = 32'hBAD;
        step();
        redirect = 1'b0; man_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rpa_flush got=%0h/%0h exp=0/0", instr_valid, mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd16 || instr_valid !== 1'b0) begin failures++; $display("FAIL rpa_req got=%0h/%0h/%0h exp=1/10/0", mem_req, mem_addr, instr_valid); end
        man_ack = 1'b1; man_rdata = 32'hC0;
        instr_ready = 1'b0;
        step();
        man_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'hC0) begin failures++; $display("FAIL rpa_data got=%0h/%0h/%0h exp=1/40/c0", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_reset_mid_wait;
        auto_ack = 1'b0; instr_ready = 1'b1;
        apply_reset();
        step();
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rmw_async got=%0h/%0h exp=0/0", mem_req, instr_valid); end
        @(posedge clk);
        #1 reset = 1'b0;
        man_ack = 1'b1; man_rdata = 32'h5A1E;
        step();
        man_ack = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rmw_stale got=%0h/%0h/%0h exp=1/0/0", mem_req, mem_addr, instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rmw_wait got=%0h exp=0", instr_valid); end
        man_ack = 1'b1; man_rdata = 32'h600D;
        step();
        man_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h600D || instr_pc !== 32'h0) begin failures++; $display("FAIL rmw_data got=%0h/%0h/%0h exp=1/600d/0", instr_valid, instr, instr_pc); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_full();
        test_delayed_ack();
        test_redirect_wait();
        test_redirect_pop_ack();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
